// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback arbiter slice.
package wb_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xlen_t;

    // One pending register-file write.
    typedef struct packed {
        reg_addr_t dst;
        xlen_t     data;
    } wb_entry_t;

    // Which source owns the write port in the current cycle.
    typedef enum logic [1:0] {
        SRC_IDLE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_FIFO = 2'd2
    } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of wb_entry_t. A push is ignored while full and a pop is
// ignored while empty; push and pop may coincide whenever the FIFO is not full.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  wb_entry_t              push_entry,
    input  logic                   pop,
    output wb_entry_t              head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    wb_entry_t       mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW:0]     count_q;
    logic            push_ok;
    logic            pop_ok;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges ALU results and buffered LSU results onto the
// single register-file write port, with starvation protection for the LSU
// queue and a busy scoreboard for long-latency destinations.
// Optional feature macro: WB_SCOREBOARD_EN builds the busy scoreboard; when
// undefined, chk_busy0/chk_busy1 read 0 and issue_valid/issue_dst are ignored.
//
// Handshake: a transfer happens on a posedge where valid && ready are both 1.
// ALU: upstream holds alu_dst/alu_data stable while alu_valid && !alu_ready.
// LSU: lsu_ready depends only on FIFO occupancy (and is 0 during reset).
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        alu_valid,
    output logic                        alu_ready,
    input  reg_addr_t                   alu_dst,
    input  xlen_t                       alu_data,
    input  logic                        lsu_valid,
    output logic                        lsu_ready,
    input  reg_addr_t                   lsu_dst,
    input  xlen_t                       lsu_data,
    input  logic                        issue_valid,
    input  reg_addr_t                   issue_dst,
    input  reg_addr_t                   chk_addr0,
    input  reg_addr_t                   chk_addr1,
    output logic                        chk_busy0,
    output logic                        chk_busy1,
    output logic                        write_en,
    output reg_addr_t                   dst_addr,
    output xlen_t                       dst_data,
    output logic [$clog2(FIFO_DEPTH):0] pending_count
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    wb_entry_t  lsu_entry;
    wb_entry_t  fifo_head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_push;
    logic       fifo_pop;

    logic       init_q;
    logic       forced;
    wb_src_e    src;

    logic [SW-1:0] starve_q, starve_d;
    logic          write_en_q, write_en_d;
    reg_addr_t     dst_addr_q, dst_addr_d;
    xlen_t         dst_data_q, dst_data_d;
    logic          from_fifo_q, from_fifo_d;

    assign lsu_entry = '{dst: lsu_dst, data: lsu_data};
    assign lsu_ready = init_q && !fifo_full;
    // Results for x0 are accepted but never stored.
    assign fifo_push = lsu_valid && lsu_ready && (lsu_dst != '0);

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (fifo_push),
        .push_entry (lsu_entry),
        .pop        (fifo_pop),
        .head       (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (pending_count)
    );

    // Holds lsu_ready low until the first edge after reset releases.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) init_q <= 1'b0;
        else       init_q <= 1'b1;
    end

    // Arbitration, starvation counter next state, and output register next state.
    always_comb begin
        src         = SRC_IDLE;
        forced      = !fifo_empty && (starve_q == SW'(STARVE_LIMIT));
        starve_d    = '0;
        write_en_d  = 1'b0;
        dst_addr_d  = dst_addr_q;
        dst_data_d  = dst_data_q;
        from_fifo_d = 1'b0;

        if (forced)           src = SRC_FIFO;
        else if (alu_valid)   src = SRC_ALU;
        else if (!fifo_empty) src = SRC_FIFO;

        if (!fifo_empty && (src == SRC_ALU)) begin
            starve_d = (starve_q == SW'(STARVE_LIMIT)) ? starve_q : starve_q + SW'(1);
        end

        case (src)
            SRC_ALU: begin
                // x0 writes are swallowed: accepted, but no register-file write.
                if (alu_dst != '0) begin
                    write_en_d = 1'b1;
                    dst_addr_d = alu_dst;
                    dst_data_d = alu_data;
                end
            end
            SRC_FIFO: begin
                write_en_d  = 1'b1;
                dst_addr_d  = fifo_head.dst;
                dst_data_d  = fifo_head.data;
                from_fifo_d = 1'b1;
            end
            default: ;
        endcase
    end

    assign alu_ready = !forced;
    assign fifo_pop  = (src == SRC_FIFO);

    // Output register and starvation counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_q    <= '0;
            write_en_q  <= 1'b0;
            dst_addr_q  <= '0;
            dst_data_q  <= '0;
            from_fifo_q <= 1'b0;
        end else begin
            starve_q    <= starve_d;
            write_en_q  <= write_en_d;
            dst_addr_q  <= dst_addr_d;
            dst_data_q  <= dst_data_d;
            from_fifo_q <= from_fifo_d;
        end
    end

    assign write_en = write_en_q;
    assign dst_addr = dst_addr_q;
    assign dst_data = dst_data_q;

`ifdef WB_SCOREBOARD_EN
    logic [NUM_REGS-1:0] busy_q, busy_d;

    // Clear on a completed FIFO write, then apply issue so a same-edge set wins.
    always_comb begin
        busy_d = busy_q;
        if (write_en_q && from_fifo_q) busy_d[dst_addr_q] = 1'b0;
        if (issue_valid && (issue_dst != '0)) busy_d[issue_dst] = 1'b1;
        busy_d[0] = 1'b0;
    end

    // Busy scoreboard register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) busy_q <= '0;
        else       busy_q <= busy_d;
    end

    assign chk_busy0 = (chk_addr0 != '0) && busy_q[chk_addr0];
    assign chk_busy1 = (chk_addr1 != '0) && busy_q[chk_addr1];
`else
    logic unused_sb;
    assign unused_sb = ^{issue_valid, issue_dst, chk_addr0, chk_addr1, from_fifo_q};
    assign chk_busy0 = 1'b0;
    assign chk_busy1 = 1'b0;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed testbench for writeback_arbiter (FIFO_DEPTH=4, STARVE_LIMIT=8).
// Busy expectations follow the WB_SCOREBOARD_EN build option.
module tb_writeback_arbiter;

    localparam bit SB_EN =
`ifdef WB_SCOREBOARD_EN
        1'b1;
`else
        1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_dst;
    logic [31:0] alu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_dst;
    logic [31:0] lsu_data;
    logic        issue_valid;
    logic [4:0]  issue_dst;
    logic [4:0]  chk_addr0;
    logic [4:0]  chk_addr1;
    logic        chk_busy0;
    logic        chk_busy1;
    logic        write_en;
    logic [4:0]  dst_addr;
    logic [31:0] dst_data;
    logic [2:0]  pending_count;

    int checks;
    int failures;

    writeback_arbiter #(
        .FIFO_DEPTH   (4),
        .STARVE_LIMIT (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .alu_valid     (alu_valid),
        .alu_ready     (alu_ready),
        .alu_dst       (alu_dst),
        .alu_data      (alu_data),
        .lsu_valid     (lsu_valid),
        .lsu_ready     (lsu_ready),
        .lsu_dst       (lsu_dst),
        .lsu_data      (lsu_data),
        .issue_valid   (issue_valid),
        .issue_dst     (issue_dst),
        .chk_addr0     (chk_addr0),
        .chk_addr1     (chk_addr1),
        .chk_busy0     (chk_busy0),
        .chk_busy1     (chk_busy1),
        .write_en      (write_en),
        .dst_addr      (dst_addr),
        .dst_data      (dst_data),
        .pending_count (pending_count)
    );

    // Clock: 10 time units, first posedge at 5.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance past one posedge; outputs are sampled 1 unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (write_en !== 1'b0) begin failures++; $display("FAIL rst_we got=%0h exp=0", write_en); end
        checks++; if (dst_addr !== 5'd0) begin failures++; $display("FAIL rst_dst got=%0h exp=0", dst_addr); end
        checks++; if (dst_data !== 32'd0) begin failures++; $display("FAIL rst_data got=%0h exp=0", dst_data); end
        checks++; if (pending_count !== 3'd0) begin failures++; $display("FAIL rst_pending got=%0h exp=0", pending_count); end
        checks++; if (alu_ready !== 1'b1) begin failures++; $display("FAIL rst_alu_ready got=%0h exp=1", alu_ready); end
        checks++; if (lsu_ready !== 1'b0) begin failures++; $display("FAIL rst_lsu_ready got=%0h exp=0", lsu_ready); end
        checks++; if (chk_busy0 !== 1'b0) begin failures++; $display("FAIL rst_busy0 got=%0h exp=0", chk_busy0); end
        step();
        step();
        reset = 1'b0;
        #1;
        checks++; if (lsu_ready !== 1'b0) begin failures++; $display("FAIL rel_lsu_ready_pre got=%0h exp=0", lsu_ready); end
        step();
        checks++; if (lsu_ready !== 1'b1) begin failures++; $display("FAIL rel_lsu_ready_post got=%0h exp=1", lsu_ready); end
    endtask

    task automatic test_alu_only();
        alu_valid = 1'b1; alu_dst = 5'd5; alu_data = 32'hDEADBEEF;
        checks++; if (alu_ready !== 1'b1) begin failures++; $display("FAIL alu_ready got=%0h exp=1", alu_ready); end
        step();
        checks++; if (write_en !== 1'b1) begin failures++; $display("FAIL alu_we got=%0h exp=1", write_en); end
        checks++; if (dst_addr !== 5'd5) begin failures++; $display("FAIL alu_dst got=%0h exp=5", dst_addr); end
        checks++; if (dst_data !== 32'hDEADBEEF) begin failures++; $display("FAIL alu_data got=%0h exp=deadbeef", dst_data); end
        alu_dst = 5'd0; alu_data = 32'h11111111;
        step();
        alu_valid = 1'b0;
        checks++; if (write_en !== 1'b0) begin failures++; $display("FAIL alu_x0_we got=%0h exp=0", write_en); end
        checks++; if (dst_addr !== 5'd5) begin failures++; $display("FAIL alu_x0_hold_dst got=%0h exp=5", dst_addr); end
        checks++; if (dst_data !== 32'hDEADBEEF) begin failures++; $display("FAIL alu_x0_hold_data got=%0h exp=deadbeef", dst_data); end
        step();
    endtask

    task automatic test_lsu_only();
        chk_addr0 = 5'd7;
        issue_valid = 1'b1; issue_dst = 5'd7;
        step();
        issue_valid = 1'b0;
        checks++; if (chk_busy0 !== SB_EN) begin failures++; $display("FAIL lsu_busy_issued got=%0h exp=%0h", chk_busy0, SB_EN); end
        lsu_valid = 1'b1; lsu_dst = 5'd7; lsu_data = 32'h1234;
        checks++; if (lsu_ready !== 1'b1) begin failures++; $display("FAIL lsu_ready got=%0h exp=1", lsu_ready); end
        step();
        lsu_valid = 1'b0;
        checks++; if (pending_count !== 3'd1) begin failures++; $display("FAIL lsu_pending1 got=%0h exp=1", pending_count); end
        checks++; if (write_en !== 1'b0) begin failures++; $display("FAIL lsu_we_early got=%0h exp=0", write_en); end
        step();
        checks++; if (write_en !== 1'b1) begin failures++; $display("FAIL lsu_we got=%0h exp=1", write_en); end
        checks++; if (dst_addr !== 5'd7) begin failures++; $display("FAIL lsu_dst got=%0h exp=7", dst_addr); end
        checks++; if (dst_data !== 32'h1234) begin failures++; $display("FAIL lsu_data got=%0h exp=1234", dst_data); end
        checks++; if (pending_count !== 3'd0) begin failures++; $display("FAIL lsu_pending0 got=%0h exp=0", pending_count); end
        checks++; if (chk_busy0 !== SB_EN) begin failures++; $display("FAIL lsu_busy_writecycle got=%0h exp=%0h", chk_busy0, SB_EN); end
        step();
        checks++; if (write_en !== 1'b0) begin failures++; $display("FAIL lsu_we_after got=%0h exp=0", write_en); end
        checks++; if (chk_busy0 !== 1'b0) begin failures++; $display("FAIL lsu_busy_cleared got=%0h exp=0", chk_busy0); end
    endtask

    task automatic test_discard_x0();
        lsu_valid = 1'b1; lsu_dst = 5'd0; lsu_data = 32'hFFFF;
        step();
        lsu_valid = 1'b0;
        checks++; if (pending_count !== 3'd0) begin failures++; $display("FAIL x0_pending got=%0h exp=0", pending_count); end
        step();
        checks++; if (write_en !== 1'b0) begin failures++; $display("FAIL x0_we got=%0h exp=0", write_en); end
    endtask

    task automatic test_fifo_full();
        alu_valid = 1'b1; alu_dst = 5'd1; alu_data = 32'h77;
        lsu_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            lsu_dst = 5'(10 + i); lsu_data = 32'h100 + 32'(i);
            step();
        end
        lsu_dst = 5'd20; lsu_data = 32'hBAD;
        checks++; if (lsu_ready !== 1'b0) begin failures++; $display("FAIL full_lsu_ready got=%0h exp=0", lsu_ready); end
        checks++; if (pending_count !== 3'd4) begin failures++; $display("FAIL full_pending got=%0h exp=4", pending_count); end
        step();
        checks++; if (pending_count !== 3'd4) begin failures++; $display("FAIL full_blocked got=%0h exp=4", pending_count); end
        lsu_valid = 1'b0; alu_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (write_en !== 1'b1) begin failures++; $display("FAIL drain_we[%0d] got=%0h exp=1", i, write_en); end
            checks++; if (dst_addr !== 5'(10 + i)) begin failures++; $display("FAIL drain_dst[%0d] got=%0h exp=%0h", i, dst_addr, 10 + i); end
            checks++; if (dst_data !== 32'h100 + 32'(i)) begin failures++; $display("FAIL drain_data[%0d] got=%0h exp=%0h", i, dst_data, 32'h100 + 32'(i)); end
            if (i == 0) begin
                checks++; if (lsu_ready !== 1'b1) begin failures++; $display("FAIL unfull_lsu_ready got=%0h exp=1", lsu_ready); end
                checks++; if (pending_count !== 3'd3) begin failures++; $display("FAIL unfull_pending got=%0h exp=3", pending_count); end
            end
        end
        step();
        checks++; if (write_en !== 1'b0) begin failures++; $display("FAIL drained_we got=%0h exp=0", write_en); end
        checks++; if (pending_count !== 3'd0) begin failures++; $display("FAIL drained_pending got=%0h exp=0", pending_count); end
    endtask

    task automatic test_starvation();
        alu_valid = 1'b1; alu_dst = 5'd3;
        lsu_valid = 1'b1; lsu_dst = 5'd4; lsu_data = 32'h5555;
        for (int i = 0; i < 9; i++) begin
            alu_data = 32'hA000 + 32'(i);
            checks++; if (alu_ready !== 1'b1) begin failures++; $display("FAIL starve_alu_ready[%0d] got=%0h exp=1", i, alu_ready); end
            step();
            lsu_valid = 1'b0;
            checks++; if (dst_data !== 32'hA000 + 32'(i)) begin failures++; $display("FAIL starve_alu_data[%0d] got=%0h exp=%0h", i, dst_data, 32'hA000 + 32'(i)); end
        end
        alu_data = 32'hA009;
        checks++; if (alu_ready !== 1'b0) begin failures++; $display("FAIL forced_alu_ready got=%0h exp=0", alu_ready); end
        checks++; if (pending_count !== 3'd1) begin failures++; $display("FAIL forced_pending got=%0h exp=1", pending_count); end
        step();
        checks++; if (write_en !== 1'b1) begin failures++; $display("FAIL forced_we got=%0h exp=1", write_en); end
        checks++; if (dst_addr !== 5'd4) begin failures++; $display("FAIL forced_dst got=%0h exp=4", dst_addr); end
        checks++; if (dst_data !== 32'h5555) begin failures++; $display("FAIL forced_data got=%0h exp=5555", dst_data); end
        checks++; if (alu_ready !== 1'b1) begin failures++; $display("FAIL post_forced_alu_ready got=%0h exp=1", alu_ready); end
        step();
        alu_valid = 1'b0;
        checks++; if (dst_addr !== 5'd3) begin failures++; $display("FAIL held_alu_dst got=%0h exp=3", dst_addr); end
        checks++; if (dst_data !== 32'hA009) begin failures++; $display("FAIL held_alu_data got=%0h exp=a009", dst_data); end
        step();
        checks++; if (write_en !== 1'b0) begin failures++; $display("FAIL starve_idle_we got=%0h exp=0", write_en); end
    endtask

    task automatic test_collision();
        chk_addr0 = 5'd9;
        issue_valid = 1'b1; issue_dst = 5'd9;
        step();
        issue_valid = 1'b0;
        lsu_valid = 1'b1; lsu_dst = 5'd9; lsu_data = 32'h9999;
        step();
        lsu_valid = 1'b0;
        step();
        checks++; if (dst_addr !== 5'd9) begin failures++; $display("FAIL coll_write_dst got=%0h exp=9", dst_addr); end
        issue_valid = 1'b1; issue_dst = 5'd9;
        step();
        issue_valid = 1'b0;
        checks++; if (chk_busy0 !== SB_EN) begin failures++; $display("FAIL coll_set_wins got=%0h exp=%0h", chk_busy0, SB_EN); end
        lsu_valid = 1'b1; lsu_dst = 5'd9; lsu_data = 32'h9A9A;
        step();
        lsu_valid = 1'b0;
        step();
        checks++; if (chk_busy0 !== SB_EN) begin failures++; $display("FAIL coll_busy_writecycle got=%0h exp=%0h", chk_busy0, SB_EN); end
        step();
        checks++; if (chk_busy0 !== 1'b0) begin failures++; $display("FAIL coll_busy_cleared got=%0h exp=0", chk_busy0); end
    endtask

    task automatic test_async_reset();
        chk_addr0 = 5'd11; chk_addr1 = 5'd12;
        issue_valid = 1'b1; issue_dst = 5'd11;
        step();
        issue_dst = 5'd12;
        step();
        issue_valid = 1'b0;
        alu_valid = 1'b1; alu_dst = 5'd2; alu_data = 32'h22;
        lsu_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            lsu_dst = 5'(13 + i); lsu_data = 32'h300 + 32'(i);
            step();
        end
        lsu_valid = 1'b0;
        checks++; if (pending_count !== 3'd3) begin failures++; $display("FAIL ar_pending_pre got=%0h exp=3", pending_count); end
        checks++; if (write_en !== 1'b1) begin failures++; $display("FAIL ar_we_pre got=%0h exp=1", write_en); end
        checks++; if (chk_busy0 !== SB_EN) begin failures++; $display("FAIL ar_busy0_pre got=%0h exp=%0h", chk_busy0, SB_EN); end
        checks++; if (chk_busy1 !== SB_EN) begin failures++; $display("FAIL ar_busy1_pre got=%0h exp=%0h", chk_busy1, SB_EN); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (write_en !== 1'b0) begin failures++; $display("FAIL ar_we got=%0h exp=0", write_en); end
        checks++; if (pending_count !== 3'd0) begin failures++; $display("FAIL ar_pending got=%0h exp=0", pending_count); end
        checks++; if (chk_busy0 !== 1'b0) begin failures++; $display("FAIL ar_busy0 got=%0h exp=0", chk_busy0); end
        checks++; if (chk_busy1 !== 1'b0) begin failures++; $display("FAIL ar_busy1 got=%0h exp=0", chk_busy1); end
        checks++; if (lsu_ready !== 1'b0) begin failures++; $display("FAIL ar_lsu_ready got=%0h exp=0", lsu_ready); end
        checks++; if (dst_addr !== 5'd0) begin failures++; $display("FAIL ar_dst got=%0h exp=0", dst_addr); end
        checks++; if (alu_ready !== 1'b1) begin failures++; $display("FAIL ar_alu_ready got=%0h exp=1", alu_ready); end
        alu_valid = 1'b0;
        step();
        reset = 1'b0;
        step();
        checks++; if (lsu_ready !== 1'b1) begin failures++; $display("FAIL ar_lsu_ready_post got=%0h exp=1", lsu_ready); end
        checks++; if (pending_count !== 3'd0) begin failures++; $display("FAIL ar_pending_post got=%0h exp=0", pending_count); end
        checks++; if (write_en !== 1'b0) begin failures++; $display("FAIL ar_we_post got=%0h exp=0", write_en); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        alu_valid = 1'b0; alu_dst = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_dst = '0; lsu_data = '0;
        issue_valid = 1'b0; issue_dst = '0;
        chk_addr0 = '0; chk_addr1 = '0;

        test_reset();
        test_alu_only();
        test_lsu_only();
        test_discard_x0();
        test_fifo_full();
        test_starvation();
        test_collision();
        test_async_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
